mem_access_unit: RTL and testbench

MEM-stage data-memory access controller sitting between the EX/MEM pipeline register and the MEM/WB register. Decodes load/store opcodes and issues a single request/ready transaction to data memory. Generates byte enables and lane-replicated store data, and sign/zero-extends load data. Stalls the pipeline until the access completes and presents MEM_RD_DATA to the MEM/WB register.

---
 rtl/mips_mem_pkg.sv | 70 +++++++
 rtl/mem_lane_align.sv | 70 +++++++
 rtl/mem_access_unit.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MEM-stage data-memory access unit:
//   - MIPS load/store opcode constants
//   - access size encoding (byte / half / word)
//   - access FSM state encoding
//   - byte-enable width
//   - decode_size(): opcode -> access size (unknown opcodes act as lw/sw)
//   - is_misaligned(): natural-alignment check for a given size and lane
// ---------------------------------------------------------------------------
package mips_mem_pkg;

  localparam int BE_W = 4;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Read decode is used whenever MemRead is set, so a read always wins over
  // a simultaneous write even if the opcode is a store.
  function automatic size_e decode_size(input logic [5:0] op, input logic is_read);
    size_e sz;
    sz = SZ_WORD;
    if (is_read) begin
      case (op)
        OP_LB, OP_LBU: sz = SZ_BYTE;
        OP_LH, OP_LHU: sz = SZ_HALF;
        OP_LW:         sz = SZ_WORD;
        default:       sz = SZ_WORD;
      endcase
    end else begin
      case (op)
        OP_SB:   sz = SZ_BYTE;
        OP_SH:   sz = SZ_HALF;
        OP_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (sz)
      SZ_HALF: mis = lane[0];
      SZ_WORD: mis = (lane != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational lane steering for the data-memory port (little-endian).
// Store side: builds byte enables and lane-replicated write data from the
// access size and the byte lane (addr[1:0]).
// Load side: picks the addressed byte/halfword out of the read word and
// sign- or zero-extends it; words pass straight through.
// Ports:
//   st_size, st_lane, st_data  store-side size, lane and raw rt value
//   be, wdata                  byte enables and replicated store data
//   ld_size, ld_signed,
//   ld_lane, rd_word           load-side size, signedness, lane, raw read word
//   rd_data                    extended load result
// ---------------------------------------------------------------------------
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  size_e           st_size,
  input  logic [1:0]      st_lane,
  input  logic [31:0]     st_data,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata,
  input  size_e           ld_size,
  input  logic            ld_signed,
  input  logic [1:0]      ld_lane,
  input  logic [31:0]     rd_word,
  output logic [31:0]     rd_data
);

  logic [7:0]  lane_byte [BE_W];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign lane_byte[gi] = rd_word[8*gi +: 8];
  end

  assign sel_byte = lane_byte[ld_lane];
  // Only lanes 0 and 2 are legal halfword starts, so bit 1 selects the half.
  assign sel_half = ld_lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    be    = '0;
    wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        be    = BE_W'(4'b0001) << st_lane;
        wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        be    = BE_W'(4'b0011) << st_lane;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    rd_data = rd_word;
    case (ld_size)
      SZ_BYTE: rd_data = {{24{ld_signed & sel_byte[7]}}, sel_byte};
      SZ_HALF: rd_data = {{16{ld_signed & sel_half[15]}}, sel_half};
      default: rd_data = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory access controller. Decodes the load/store in the
// MEM stage, issues one request/ready transaction to data memory, stalls the
// pipeline while it is outstanding and hands the extended load result to
// the MEM/WB register. Occupancy is IDLE -> WAIT (1..n) -> DONE.
// Misaligned accesses never reach the bus; they raise MEM_MISALIGN for one
// cycle and zero MEM_RD_DATA.
// Optional build macro: MEM_TIMEOUT_EN -- when defined, a WAIT that sees no
// DMEM_READY for TIMEOUT_CYCLES cycles is aborted with a one-cycle
// MEM_BUS_ERR pulse; when undefined MEM_BUS_ERR is tied low.
// Ports:
//   CLK, RESET_N                      clock, async active-low reset
//   MEM_MemRead/MemWrite/Opcode       MEM-stage control
//   MEM_ALU_RESULT, MEM_WR_DATA       effective address, store value
//   DMEM_REQ/WE/ADDR/BE/WDATA         registered request to data memory
//   DMEM_READY, DMEM_RDATA            memory response
//   MEM_RD_DATA                       extended load result
//   MEM_STALL                         pipeline freeze (combinational)
//   MEM_MISALIGN, MEM_BUS_ERR         one-cycle error flags
// ---------------------------------------------------------------------------
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [5:0]        MEM_Opcode,
  input  logic [31:0]       MEM_ALU_RESULT,
  input  logic [31:0]       MEM_WR_DATA,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [ADDR_W-1:0] DMEM_ADDR,
  output logic [BE_W-1:0]   DMEM_BE,
  output logic [31:0]       DMEM_WDATA,
  input  logic              DMEM_READY,
  input  logic [31:0]       DMEM_RDATA,
  output logic [31:0]       MEM_RD_DATA,
  output logic              MEM_STALL,
  output logic              MEM_MISALIGN,
  output logic              MEM_BUS_ERR
);

  state_e state_reg, state_next;

  logic        access, is_read, mis;
  logic        stall, issue, complete, abort, timeout_hit;
  size_e       req_size;
  logic        req_signed;
  logic [1:0]  req_lane;

  logic [BE_W-1:0] be_calc;
  logic [31:0]     wdata_calc, rd_ext;

  logic              req_reg, we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [BE_W-1:0]   be_reg;
  logic [31:0]       wdata_reg, rd_data_reg;
  logic              misalign_reg, bus_err_reg;
  size_e             ld_size_reg;
  logic              ld_signed_reg;
  logic [1:0]        ld_lane_reg;

  assign access     = MEM_MemRead | MEM_MemWrite;
  assign is_read    = MEM_MemRead;
  assign req_size   = decode_size(MEM_Opcode, is_read);
  assign req_signed = is_read & ((MEM_Opcode == OP_LB) | (MEM_Opcode == OP_LH));
  assign req_lane   = MEM_ALU_RESULT[1:0];
  assign mis        = access & is_misaligned(req_size, req_lane);

  // Store steering uses the live MEM-stage instruction; load extraction uses
  // the size/lane captured at issue since the read word arrives later.
  mem_lane_align u_align (
    .st_size   (req_size),
    .st_lane   (req_lane),
    .st_data   (MEM_WR_DATA),
    .be        (be_calc),
    .wdata     (wdata_calc),
    .ld_size   (ld_size_reg),
    .ld_signed (ld_signed_reg),
    .ld_lane   (ld_lane_reg),
    .rd_word   (DMEM_RDATA),
    .rd_data   (rd_ext)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_reg;

  // The current non-READY cycle is the one that brings the count up to
  // TIMEOUT_CYCLES, so the abort fires when the stored count is one short.
  assign timeout_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == S_WAIT) && !DMEM_READY && !timeout_hit) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end else begin
      tmo_cnt_reg <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    issue      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (access && !mis) begin
          stall      = 1'b1;
          issue      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (DMEM_READY) begin
          complete   = 1'b1;
          state_next = S_DONE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      req_reg       <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      be_reg        <= '0;
      wdata_reg     <= '0;
      rd_data_reg   <= '0;
      misalign_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
      ld_size_reg   <= SZ_BYTE;
      ld_signed_reg <= 1'b0;
      ld_lane_reg   <= 2'b00;
    end else begin
      misalign_reg <= (state_reg == S_IDLE) & mis;
      bus_err_reg  <= abort;
      if (issue) begin
        req_reg       <= 1'b1;
        we_reg        <= ~is_read;
        addr_reg      <= {MEM_ALU_RESULT[ADDR_W-1:2], 2'b00};
        be_reg        <= be_calc;
        wdata_reg     <= wdata_calc;
        ld_size_reg   <= req_size;
        ld_signed_reg <= req_signed;
        ld_lane_reg   <= req_lane;
      end
      if (complete) begin
        req_reg <= 1'b0;
        if (!we_reg) begin
          rd_data_reg <= rd_ext;
        end
      end
      if (abort) begin
        req_reg     <= 1'b0;
        rd_data_reg <= '0;
      end
      if ((state_reg == S_IDLE) && mis) begin
        rd_data_reg <= '0;
      end
    end
  end

  assign DMEM_REQ     = req_reg;
  assign DMEM_WE      = we_reg;
  assign DMEM_ADDR    = addr_reg;
  assign DMEM_BE      = be_reg;
  assign DMEM_WDATA   = wdata_reg;
  assign MEM_RD_DATA  = rd_data_reg;
  assign MEM_MISALIGN = misalign_reg;
  assign MEM_BUS_ERR  = bus_err_reg;
  // Gated by reset so the pipeline is never frozen while the unit is held.
  assign MEM_STALL    = RESET_N & stall;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Scoreboard bench for mem_access_unit. The driver issues load/store
// instructions (directed cases, then random ones), plays the memory side,
// and pushes the expected bus request and completion into a queue computed
// from a plain arithmetic reference model. A monitor watches the DUT on the
// falling clock edge and pops/compares on each request, completion and
// misalign pulse. Honours MEM_TIMEOUT_EN to choose the timeout scenario.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int TMO    = 4;
  localparam int K_REQ  = 0;
  localparam int K_DONE = 1;
  localparam int K_MIS  = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic        chk_wdata;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          stall;
    logic        berr;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        MEM_MemRead, MEM_MemWrite;
  logic [5:0]  MEM_Opcode;
  logic [31:0] MEM_ALU_RESULT, MEM_WR_DATA;
  logic        DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_WDATA;
  logic        DMEM_READY;
  logic [31:0] DMEM_RDATA;
  logic [31:0] MEM_RD_DATA;
  logic        MEM_STALL, MEM_MISALIGN, MEM_BUS_ERR;

  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q[$];
  logic [31:0] model_rd;
  logic [5:0]  ops [9] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h0F};

  always #5 CLK = ~CLK;

  mem_access_unit #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_MemWrite   (MEM_MemWrite),
    .MEM_Opcode     (MEM_Opcode),
    .MEM_ALU_RESULT (MEM_ALU_RESULT),
    .MEM_WR_DATA    (MEM_WR_DATA),
    .DMEM_REQ       (DMEM_REQ),
    .DMEM_WE        (DMEM_WE),
    .DMEM_ADDR      (DMEM_ADDR),
    .DMEM_BE        (DMEM_BE),
    .DMEM_WDATA     (DMEM_WDATA),
    .DMEM_READY     (DMEM_READY),
    .DMEM_RDATA     (DMEM_RDATA),
    .MEM_RD_DATA    (MEM_RD_DATA),
    .MEM_STALL      (MEM_STALL),
    .MEM_MISALIGN   (MEM_MISALIGN),
    .MEM_BUS_ERR    (MEM_BUS_ERR)
  );

  // ---------------- reference model ----------------
  function automatic int size_of(input bit rd, input logic [5:0] op);
    if (rd) begin
      if (op == 6'h20 || op == 6'h24) return 1;
      if (op == 6'h21 || op == 6'h25) return 2;
      return 4;
    end
    if (op == 6'h28) return 1;
    if (op == 6'h29) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] be_model(input int sz, input logic [31:0] addr);
    logic [7:0] m;
    m = ((8'd1 << sz) - 8'd1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] wdata_model(input int sz, input logic [31:0] wd);
    if (sz == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] load_model(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int          sz;
    logic [31:0] mask, v;
    sz   = size_of(1'b1, op);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (rdata >> (8 * (addr % 4))) & mask;
    if ((op == 6'h20 || op == 6'h21) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic take_exp(input int kind, output exp_t e, output bit ok);
    total++;
    e = '{default: 0};
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event_%0d actual=unexpected_event required=no_event", kind);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        bad++;
        $display("FAIL event_order actual=kind%0d required=kind%0d", kind, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit          prev_req, stall_prev, ok, done_evt;
    int          stall_run;
    exp_t        e;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;
    logic        h_we;
    prev_req   = 1'b0;
    stall_prev = 1'b0;
    stall_run  = 0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        chk("rst_req", {31'd0, DMEM_REQ}, 32'd0);
        chk("rst_we", {31'd0, DMEM_WE}, 32'd0);
        chk("rst_addr", DMEM_ADDR, 32'd0);
        chk("rst_be", {28'd0, DMEM_BE}, 32'd0);
        chk("rst_wdata", DMEM_WDATA, 32'd0);
        chk("rst_rd_data", MEM_RD_DATA, 32'd0);
        chk("rst_stall", {31'd0, MEM_STALL}, 32'd0);
        chk("rst_misalign", {31'd0, MEM_MISALIGN}, 32'd0);
        chk("rst_bus_err", {31'd0, MEM_BUS_ERR}, 32'd0);
        prev_req   = 1'b0;
        stall_prev = 1'b0;
        stall_run  = 0;
        continue;
      end
      done_evt = 1'b0;
      if (DMEM_REQ && !prev_req) begin
        take_exp(K_REQ, e, ok);
        if (ok) begin
          chk("req_addr", DMEM_ADDR, e.addr);
          chk("req_be", {28'd0, DMEM_BE}, {28'd0, e.be});
          chk("req_we", {31'd0, DMEM_WE}, {31'd0, e.we});
          if (e.chk_wdata) chk("req_wdata", DMEM_WDATA, e.wdata);
        end
        h_addr = DMEM_ADDR; h_be = DMEM_BE; h_we = DMEM_WE; h_wdata = DMEM_WDATA;
      end else if (DMEM_REQ && prev_req) begin
        chk("hold_addr", DMEM_ADDR, h_addr);
        chk("hold_be", {28'd0, DMEM_BE}, {28'd0, h_be});
        chk("hold_we", {31'd0, DMEM_WE}, {31'd0, h_we});
        chk("hold_wdata", DMEM_WDATA, h_wdata);
      end
      if (!DMEM_REQ && prev_req) begin
        done_evt = 1'b1;
        take_exp(K_DONE, e, ok);
        if (ok) begin
          chk("done_rd_data", MEM_RD_DATA, e.rd);
          chk("done_stall_cycles", stall_run, e.stall);
          chk("done_stall_low", {31'd0, MEM_STALL}, 32'd0);
          chk("done_bus_err", {31'd0, MEM_BUS_ERR}, {31'd0, e.berr});
        end
        $display("txn done rd_data=%h stall_cycles=%0d bus_err=%0b", MEM_RD_DATA, stall_run,
                 MEM_BUS_ERR);
      end
      if (MEM_MISALIGN) begin
        take_exp(K_MIS, e, ok);
        if (ok) begin
          chk("mis_rd_data", MEM_RD_DATA, 32'd0);
          chk("mis_no_stall", {31'd0, stall_prev}, 32'd0);
        end
        $display("txn misaligned rd_data=%h", MEM_RD_DATA);
      end
      if (MEM_BUS_ERR && !done_evt) chk("bus_err_spurious", {31'd0, MEM_BUS_ERR}, 32'd0);
      stall_run  = MEM_STALL ? stall_run + 1 : 0;
      stall_prev = MEM_STALL;
      prev_req   = DMEM_REQ;
    end
  end

  // ---------------- driver ----------------
  task automatic clear_inputs();
    MEM_MemRead    = 1'b0;
    MEM_MemWrite   = 1'b0;
    MEM_Opcode     = 6'($urandom);
    MEM_ALU_RESULT = $urandom;
    MEM_WR_DATA    = $urandom;
  endtask

  task automatic mem_op(input bit rd, input bit wr, input logic [5:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, input int waits,
                        input bit give_ready, input logic [31:0] rdata);
    exp_t e;
    int   sz;
    bit   mis;
    sz  = size_of(rd, op);
    mis = (rd | wr) && ((addr % sz) != 0);
    MEM_MemRead    = rd;
    MEM_MemWrite   = wr;
    MEM_Opcode     = op;
    MEM_ALU_RESULT = addr;
    MEM_WR_DATA    = wd;
    if (!(rd | wr) || mis) begin
      if (mis) begin
        e = '{default: 0};
        e.kind = K_MIS;
        exp_q.push_back(e);
        model_rd = 32'd0;
      end
      DMEM_READY = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      DMEM_READY = 1'b0;
      clear_inputs();
      return;
    end
    e = '{default: 0};
    e.kind      = K_REQ;
    e.addr      = addr & ~32'h3;
    e.be        = be_model(sz, addr);
    e.we        = ~rd;
    e.chk_wdata = ~rd;
    e.wdata     = wdata_model(sz, wd);
    exp_q.push_back(e);
    if (!give_ready) model_rd = 32'd0;
    else if (rd) model_rd = load_model(op, addr, rdata);
    e = '{default: 0};
    e.kind  = K_DONE;
    e.rd    = model_rd;
    e.stall = give_ready ? 2 + waits : 1 + TMO;
    e.berr  = ~give_ready;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    if (give_ready) begin
      repeat (waits) begin @(posedge CLK); #1; end
      DMEM_READY = 1'b1;
      DMEM_RDATA = rdata;
      @(posedge CLK); #1;
    end else begin
      repeat (TMO) begin @(posedge CLK); #1; end
    end
    // DONE cycle: instruction still present, READY noise must be ignored
    DMEM_READY = 1'($urandom_range(0, 1));
    DMEM_RDATA = $urandom;
    @(posedge CLK); #1;
    DMEM_READY = 1'b0;
    clear_inputs();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int          r;
    bit          rd, wr;
    logic [5:0]  op;
    model_rd   = 32'd0;
    RESET_N    = 1'b0;
    DMEM_READY = 1'b0;
    DMEM_RDATA = 32'd0;
    clear_inputs();
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;

    // directed cases
    mem_op(1, 0, 6'h23, 32'h100, 32'h0, 1, 1, 32'h1234_5678);
    mem_op(1, 0, 6'h20, 32'h203, 32'h0, 0, 1, 32'h80FF_1234);
    mem_op(1, 0, 6'h24, 32'h203, 32'h0, 0, 1, 32'h80FF_1234);
    mem_op(1, 0, 6'h25, 32'h202, 32'h0, 2, 1, 32'h80FF_1234);
    mem_op(0, 1, 6'h29, 32'h302, 32'h0000_BEEF, 0, 1, 32'h0);
    mem_op(0, 1, 6'h28, 32'h301, 32'h0000_00AB, 1, 1, 32'h0);
    mem_op(1, 0, 6'h23, 32'h102, 32'h0, 0, 1, 32'h0);
    mem_op(0, 1, 6'h2B, 32'h500, 32'hCAFE_F00D, 0, 1, 32'h0);
    mem_op(1, 1, 6'h29, 32'h604, 32'h5555_AAAA, 0, 1, 32'h8765_4321);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 9);
      rd = (r == 1) || (r >= 2 && r <= 5);
      wr = (r == 1) || (r >= 6);
      op = ops[$urandom_range(0, 8)];
      mem_op(rd, wr, op, $urandom, $urandom, $urandom_range(0, 3), 1, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        DMEM_READY = 1'($urandom_range(0, 1));
        @(posedge CLK); #1;
        DMEM_READY = 1'b0;
      end
    end

`ifdef MEM_TIMEOUT_EN
    mem_op(1, 0, 6'h23, 32'h700, 32'h0, 0, 0, 32'h0);
`else
    mem_op(1, 0, 6'h23, 32'h700, 32'h0, 10, 1, 32'h0BAD_BEEF);
`endif
    mem_op(0, 1, 6'h28, 32'h703, 32'h0000_0011, 0, 1, 32'h0);

    // reset while the request is outstanding
    MEM_MemRead    = 1'b1;
    MEM_MemWrite   = 1'b0;
    MEM_Opcode     = 6'h23;
    MEM_ALU_RESULT = 32'h400;
    begin
      exp_t e;
      e = '{default: 0};
      e.kind = K_REQ;
      e.addr = 32'h400;
      e.be   = 4'hF;
      exp_q.push_back(e);
    end
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    #1;
    chk("reset_req_async", {31'd0, DMEM_REQ}, 32'd0);
    chk("reset_stall", {31'd0, MEM_STALL}, 32'd0);
    exp_q.delete();
    model_rd = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    clear_inputs();
    RESET_N = 1'b1;
    mem_op(1, 0, 6'h23, 32'h104, 32'h0, 0, 1, 32'hA5A5_0F0F);

    repeat (3) @(posedge CLK);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
